// File: rtl/medidor_frecuencia.sv
// rtl/medidor_frecuencia.sv - half-period meter for a slow square wave against reloj3
//
// Purpose:
//   Counts reloj3 cycles between consecutive edges (rising or falling) of an
//   asynchronous input and reports that half-period. The result is also
//   compared against an expected half-period, and loss of signal is flagged
//   when no edge arrives within MAX_CUENTA cycles.
//
// Ports:
//   reloj3     in   1      system clock, all logic on its rising edge
//   reset      in   1      asynchronous, active-high reset
//   entrada    in   1      signal under measurement, asynchronous to reloj3
//   medida     out  ANCHO  last measured half-period in reloj3 cycles
//   valido     out  1      one-cycle pulse when medida is updated
//   en_rango   out  1      |medida - ESPERADO| <= TOLERANCIA, updated with medida
//   sin_senal  out  1      no edge seen for MAX_CUENTA cycles

module medidor_frecuencia #(
   parameter int unsigned ANCHO      = 18,
   parameter int unsigned ESPERADO   = 125001,
   parameter int unsigned TOLERANCIA = 50,
   parameter int unsigned MAX_CUENTA = 250000
) (
   input  logic             reloj3,
   input  logic             reset,
   input  logic             entrada,
   output logic [ANCHO-1:0] medida,
   output logic             valido,
   output logic             en_rango,
   output logic             sin_senal
);

   // The comparison is done one bit wider than the counter so that the
   // subtraction never wraps, whichever operand is larger.
   localparam logic [ANCHO:0]   ESPERADO_W   = (ANCHO+1)'(ESPERADO);
   localparam logic [ANCHO:0]   TOLERANCIA_W = (ANCHO+1)'(TOLERANCIA);
   localparam logic [ANCHO-1:0] MAX_W        = ANCHO'(MAX_CUENTA);

   typedef enum logic {
      ESPERA,
      MIDIENDO
   } estado_t;

   estado_t          estado_q;

   // Two-flop synchroniser, one extra stage to compare against, and a
   // registered edge pulse.
   logic             sinc1_q;
   logic             sinc2_q;
   logic             sinc3_q;
   logic             flanco_q;

   logic [ANCHO-1:0] cuenta_q;
   logic [ANCHO-1:0] cuenta_d;
   logic [ANCHO-1:0] medida_q;
   logic             valido_q;
   logic             en_rango_q;
   logic             en_rango_d;
   logic             sin_senal_q;

   logic [ANCHO:0]   cuenta_ext;
   logic [ANCHO:0]   diferencia;

   // Counter: an edge restarts at 1 so that the value seen on the next edge
   // equals the number of cycles between the two edges; otherwise it climbs
   // and sticks at MAX_CUENTA.
   always_comb begin
      cuenta_d = cuenta_q;
      if (flanco_q) begin
         cuenta_d = ANCHO'(1);
      end else if (cuenta_q != MAX_W) begin
         cuenta_d = cuenta_q + 1'b1;
      end
   end

   always_comb begin
      cuenta_ext = {1'b0, cuenta_q};
      diferencia = (cuenta_ext >= ESPERADO_W) ? (cuenta_ext - ESPERADO_W)
                                              : (ESPERADO_W - cuenta_ext);
      en_rango_d = (diferencia <= TOLERANCIA_W);
   end

   always_ff @(posedge reloj3 or posedge reset) begin
      if (reset) begin
         sinc1_q     <= 1'b0;
         sinc2_q     <= 1'b0;
         sinc3_q     <= 1'b0;
         flanco_q    <= 1'b0;
         cuenta_q    <= '0;
         medida_q    <= '0;
         valido_q    <= 1'b0;
         en_rango_q  <= 1'b0;
         sin_senal_q <= 1'b0;
         estado_q    <= ESPERA;
      end else begin
         sinc1_q  <= entrada;
         sinc2_q  <= sinc1_q;
         sinc3_q  <= sinc2_q;
         flanco_q <= sinc2_q ^ sinc3_q;
         cuenta_q <= cuenta_d;
         valido_q <= 1'b0;

         case (estado_q)
            ESPERA: begin
               // First edge only establishes the reference point.
               if (flanco_q) begin
                  estado_q <= MIDIENDO;
               end
            end
            MIDIENDO: begin
               if (cuenta_q == MAX_W) begin
                  // Timeout beats a coincident edge; that edge still becomes
                  // the new reference, so measuring continues from it.
                  sin_senal_q <= 1'b1;
                  estado_q    <= flanco_q ? MIDIENDO : ESPERA;
               end else if (flanco_q) begin
                  medida_q    <= cuenta_q;
                  valido_q    <= 1'b1;
                  en_rango_q  <= en_rango_d;
                  sin_senal_q <= 1'b0;
               end
            end
            default: begin
               estado_q <= ESPERA;
            end
         endcase
      end
   end

   assign medida    = medida_q;
   assign valido    = valido_q;
   assign en_rango  = en_rango_q;
   assign sin_senal = sin_senal_q;

endmodule

// File: tb/tb_medidor_frecuencia.sv
// tb/tb_medidor_frecuencia.sv - randomized self-checking bench for medidor_frecuencia

module tb_medidor_frecuencia;

   localparam int ANCHO      = 10;
   localparam int ESPERADO   = 100;
   localparam int TOLERANCIA = 2;
   localparam int MAX_CUENTA = 300;

   logic             reloj3;
   logic             reset;
   logic             entrada;
   logic [ANCHO-1:0] medida;
   logic             valido;
   logic             en_rango;
   logic             sin_senal;

   int n_comp;
   int n_fail;

   medidor_frecuencia #(
      .ANCHO      (ANCHO),
      .ESPERADO   (ESPERADO),
      .TOLERANCIA (TOLERANCIA),
      .MAX_CUENTA (MAX_CUENTA)
   ) dut (
      .reloj3    (reloj3),
      .reset     (reset),
      .entrada   (entrada),
      .medida    (medida),
      .valido    (valido),
      .en_rango  (en_rango),
      .sin_senal (sin_senal)
   );

   initial reloj3 = 1'b0;
   always #5 reloj3 = ~reloj3;

   // Reference model: works on edge timestamps. An entrada change becomes a
   // measurement event 3 clock edges after it is first sampled; the
   // half-period is the difference between consecutive event timestamps.
   logic [4:0] muestras;
   int         t_ahora;
   int         t_ref;
   bit         midiendo;
   int         m_medida;
   bit         m_valido;
   bit         m_en_rango;
   bit         m_sin_senal;

   always @(posedge reloj3 or posedge reset) begin
      if (reset) begin
         muestras    = '0;
         t_ahora     = 0;
         t_ref       = 0;
         midiendo    = 0;
         m_medida    = 0;
         m_valido    = 0;
         m_en_rango  = 0;
         m_sin_senal = 0;
      end else begin
         int  d;
         bit  evento;
         t_ahora  = t_ahora + 1;
         muestras = {muestras[3:0], entrada};
         evento   = muestras[3] ^ muestras[4];
         m_valido = 0;
         d        = t_ahora - t_ref;
         if (midiendo && d >= MAX_CUENTA) begin
            m_sin_senal = 1;
            if (evento) t_ref = t_ahora;
            else        midiendo = 0;
         end else if (evento) begin
            if (midiendo) begin
               m_medida    = d;
               m_valido    = 1;
               m_en_rango  = ((d > ESPERADO) ? d - ESPERADO : ESPERADO - d) <= TOLERANCIA;
               m_sin_senal = 0;
            end
            midiendo = 1;
            t_ref    = t_ahora;
         end
      end
   end

   task automatic chequear(input string tag, input int obs, input int esp);
      n_comp = n_comp + 1;
      if (obs != esp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, esp, $time);
      end
   endtask

   task automatic chequear_salidas(input string tag);
      chequear({tag, ".medida"},    int'(medida),    m_medida);
      chequear({tag, ".valido"},    int'(valido),    int'(m_valido));
      chequear({tag, ".en_rango"},  int'(en_rango),  int'(m_en_rango));
      chequear({tag, ".sin_senal"}, int'(sin_senal), int'(m_sin_senal));
   endtask

   // Drive one cycle of entrada and check all outputs on the falling edge.
   task automatic ciclo(input logic e, input string tag);
      entrada = e;
      @(posedge reloj3);
      @(negedge reloj3);
      chequear_salidas(tag);
   endtask

   // Toggle entrada now, then hold it so the next toggle is n cycles later.
   task automatic semiperiodo(input int n, input string tag);
      ciclo(~entrada, tag);
      for (int i = 1; i < n; i++) ciclo(entrada, tag);
   endtask

   // Asynchronous reset pulse asserted and released away from the clock edge.
   task automatic pulso_reset();
      @(negedge reloj3);
      #2 reset = 1'b1;
      #1;
      chequear("rst.medida",    int'(medida),    0);
      chequear("rst.valido",    int'(valido),    0);
      chequear("rst.en_rango",  int'(en_rango),  0);
      chequear("rst.sin_senal", int'(sin_senal), 0);
      @(negedge reloj3);
      #3 reset = 1'b0;
   endtask

   initial begin
      n_comp  = 0;
      n_fail  = 0;
      reset   = 1'b1;
      entrada = 1'b0;
      repeat (2) @(posedge reloj3);
      @(negedge reloj3);
      chequear_salidas("reset");
      #3 reset = 1'b0;

      // Nominal: half-period 100, first toggle is only a reference.
      for (int i = 0; i < 6; i++) semiperiodo(100, "nominal");
      chequear("nominal.medida_100", int'(medida), 100);
      chequear("nominal.en_rango_1", int'(en_rango), 1);

      // Tolerance boundary on both sides of ESPERADO.
      semiperiodo(102, "tol102");
      semiperiodo(103, "tol103");
      semiperiodo(98,  "tol98");
      semiperiodo(97,  "tol97");
      semiperiodo(100, "tol_end");
      for (int i = 0; i < 8; i++) ciclo(entrada, "tol_settle");

      // Loss of signal: steady toggling, then hold well past MAX_CUENTA.
      for (int i = 0; i < 3; i++) semiperiodo(100, "loss_pre");
      for (int i = 0; i < 400; i++) ciclo(entrada, "loss_hold");
      chequear("loss.sin_senal_1", int'(sin_senal), 1);
      chequear("loss.medida_held", int'(medida), 100);
      for (int i = 0; i < 3; i++) semiperiodo(100, "loss_resume");

      // Timeout coinciding with an edge, then a normal measurement.
      semiperiodo(300, "simul_ref");
      semiperiodo(100, "simul_edge");
      semiperiodo(100, "simul_after");
      for (int i = 0; i < 8; i++) ciclo(entrada, "simul_settle");

      // Randomized half-periods spanning short, nominal and timeout ranges.
      for (int i = 0; i < 20; i++) semiperiodo(int'($urandom_range(1, 320)), "rand");
      for (int i = 0; i < 12; i++) semiperiodo(int'($urandom_range(1, 3)), "rand_short");
      for (int i = 0; i < 8; i++) semiperiodo(int'($urandom_range(95, 105)), "rand_near");

      // Reset in the middle of a measurement discards the partial count.
      semiperiodo(50, "mid_pre");
      pulso_reset();
      for (int i = 0; i < 4; i++) semiperiodo(100, "mid_post");
      chequear("mid.medida_100", int'(medida), 100);
      for (int i = 0; i < 8; i++) ciclo(entrada, "final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
      $finish;
   end

endmodule
